// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver.
// Shadows the BCD digits and decimal points once per frame so a frame never mixes
// old and new values, then scans one digit at a time onto shared segment lines.
// Supports optional leading-zero blanking and per-digit blink.
module seg_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int CLK_SET        = 50_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLINK_HZ       = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_en,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int SCAN_DIV  = CLK_SET / (SCAN_HZ * DIGITS);
  localparam int BLINK_DIV = CLK_SET / (2 * BLINK_HZ);
  localparam int DIV_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIV_W-1:0]      div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                  phase_q, phase_d;
  logic [4*DIGITS-1:0]   shadow_bcd_q, shadow_bcd_d;
  logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic                  load_q, load_d;
  logic [7:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  logic                  div_wrap;
  logic                  idx_wrap;
  logic                  blink_wrap;
  logic                  frame_wrap;
  logic [4*DIGITS-1:0]   src_bcd;
  logic [DIGITS-1:0]     src_dp;
  logic [3:0]            digit;
  logic                  zero_from_idx;
  logic                  lz_blank;
  logic                  blink_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Terminal-count detection and selection of the digit currently being scanned.
  // Right after reset the shadow is still empty, so the incoming value is shown directly
  // on the same edge it is captured.
  always_comb begin
    div_wrap    = (div_q == DIV_W'(SCAN_DIV - 1));
    idx_wrap    = (idx_q == IDX_W'(DIGITS - 1));
    blink_wrap  = (blink_cnt_q == BLK_W'(BLINK_DIV - 1));
    frame_wrap  = en && div_wrap && idx_wrap;
    src_bcd     = load_q ? bcd_in : shadow_bcd_q;
    src_dp      = load_q ? dp_in  : shadow_dp_q;
    digit       = src_bcd[4*int'(idx_q) +: 4];
    zero_from_idx = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(idx_q) && src_bcd[4*j +: 4] != 4'd0) begin
        zero_from_idx = 1'b0;
      end
    end
    lz_blank    = blank_lz && (idx_q != '0) && zero_from_idx;
    blink_blank = phase_q && blink_en[idx_q];
  end

  // Next-state: counters advance only while enabled; outputs go dark when disabled or blanked.
  always_comb begin
    div_d        = div_q;
    idx_d        = idx_q;
    blink_cnt_d  = blink_cnt_q;
    phase_d      = phase_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    load_d       = load_q;
    frame_done_d = 1'b0;
    seg_d        = 8'h00;
    an_d         = '0;
    if (en) begin
      if (div_wrap) begin
        div_d = '0;
        idx_d = idx_wrap ? '0 : idx_q + IDX_W'(1);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
      if (blink_wrap) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
      if (load_q || frame_wrap) begin
        shadow_bcd_d = bcd_in;
        shadow_dp_d  = dp_in;
        load_d       = 1'b0;
      end
      frame_done_d = frame_wrap;
      if (!(lz_blank || blink_blank)) begin
        an_d[idx_q] = 1'b1;
        seg_d       = {src_dp[idx_q], seg_decode(digit)};
      end
    end
  end

  // State register with synchronous reset; the load flag captures inputs on the first enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      idx_q        <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      load_q       <= 1'b1;
      seg_q        <= 8'h00;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      load_q       <= load_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Pin polarity applied after the registers; all-zero internal state means all lamps off.
  always_comb begin
    seg        = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    an         = (AN_ACTIVE_LOW != 0) ? ~an_q : an_q;
    frame_done = frame_done_q;
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 10;
  localparam int BLINK_DIV = 200;
  localparam int FRAME     = SCAN_DIV * DIGITS;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  blink_en;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // reference model state: enabled-edge count since reset, captured frame, pending first load
  int          n;
  bit          load;
  logic [15:0] m_bcd;
  logic [3:0]  m_dp;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_fd;

  logic [6:0] seg_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  seg_scan_driver #(
    .DIGITS(4), .CLK_SET(800), .SCAN_HZ(20), .BLINK_HZ(2),
    .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .bcd_in(bcd_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .blink_en(blink_en),
    .seg(seg), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Expected outputs after this edge, derived from elapsed enabled cycles.
  task automatic model_step();
    int          pos;
    int          idx;
    bit          phase;
    logic [15:0] sb;
    logic [3:0]  sd;
    int          d;
    bit          lz;
    bit          bl;
    if (rst) begin
      n = 0; load = 1; m_bcd = '0; m_dp = '0;
      exp_seg = 8'h00; exp_an = 4'h0; exp_fd = 1'b0;
    end else if (!en) begin
      exp_seg = 8'h00; exp_an = 4'h0; exp_fd = 1'b0;
    end else begin
      pos   = n % FRAME;
      idx   = pos / SCAN_DIV;
      phase = ((n / BLINK_DIV) % 2) == 1;
      sb    = load ? bcd_in : m_bcd;
      sd    = load ? dp_in  : m_dp;
      d     = int'((sb >> (4*idx)) & 16'hF);
      lz    = blank_lz && idx > 0 && ((sb >> (4*idx)) == 16'h0);
      bl    = phase && blink_en[idx];
      if (lz || bl) begin
        exp_seg = 8'h00; exp_an = 4'h0;
      end else begin
        exp_an  = 4'(1 << idx);
        exp_seg = {sd[idx], seg_tab[d]};
      end
      exp_fd = (pos == FRAME - 1);
      if (load || exp_fd) begin
        m_bcd = bcd_in; m_dp = dp_in;
      end
      load = 0;
      n++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("seg", seg, exp_seg);
    check("an", {4'h0, an}, {4'h0, exp_an});
    check("frame_done", {7'h0, frame_done}, {7'h0, exp_fd});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; bcd_in = 16'h0; dp_in = 4'h0; blank_lz = 1'b0; blink_en = 4'h0;
    n = 0; load = 1; m_bcd = '0; m_dp = '0; exp_seg = '0; exp_an = '0; exp_fd = 1'b0;

    // reset state
    repeat (3) tick();
    check("rst_seg", seg, 8'h00);
    check("rst_an", {4'h0, an}, 8'h00);
    check("rst_fd", {7'h0, frame_done}, 8'h00);

    // basic scan order and frame pulse
    bcd_in = 16'h1234;
    rst = 1'b0;
    for (int k = 1; k <= 85; k++) begin
      tick();
      if (k == 1)  begin check("t1_d0_seg", seg, 8'h66); check("t1_d0_an", {4'h0, an}, 8'h01); end
      if (k == 10) check("t1_d0_dwell", {4'h0, an}, 8'h01);
      if (k == 11) begin check("t1_d1_seg", seg, 8'h4F); check("t1_d1_an", {4'h0, an}, 8'h02); end
      if (k == 21) begin check("t1_d2_seg", seg, 8'h5B); check("t1_d2_an", {4'h0, an}, 8'h04); end
      if (k == 31) begin check("t1_d3_seg", seg, 8'h06); check("t1_d3_an", {4'h0, an}, 8'h08); end
      if (k == 39 || k == 41) check("t1_fd_low", {7'h0, frame_done}, 8'h00);
      if (k == 40 || k == 80) check("t1_fd_pulse", {7'h0, frame_done}, 8'h01);
    end

    // mid-frame input change is deferred to next frame
    bcd_in = 16'h0012;
    do_reset();
    for (int k = 1; k <= 90; k++) begin
      tick();
      if (k == 15) bcd_in = 16'h5678;
      if (k == 16) check("t2_old_d1", seg, 8'h06);
      if (k == 21) check("t2_old_d2", seg, 8'h3F);
      if (k == 41) check("t2_new_d0", seg, 8'h7F);
      if (k == 51) check("t2_new_d1", seg, 8'h07);
    end

    // leading-zero blanking
    blank_lz = 1'b1; bcd_in = 16'h0005;
    do_reset();
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (k == 1)  begin check("t3_d0_seg", seg, 8'h6D); check("t3_d0_an", {4'h0, an}, 8'h01); end
      if (k == 11 || k == 21 || k == 31) check("t3_lz_an", {4'h0, an}, 8'h00);
    end
    bcd_in = 16'h0000;
    do_reset();
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (k == 1)  check("t3_zero_d0", seg, 8'h3F);
      if (k == 11) check("t3_zero_d1_an", {4'h0, an}, 8'h00);
    end

    // out-of-range codes and decimal point
    blank_lz = 1'b0; bcd_in = 16'hA00F; dp_in = 4'b0010;
    do_reset();
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (k == 1)  check("t4_d0_dash", seg, 8'h40);
      if (k == 11) check("t4_d1_dp", seg, 8'hBF);
      if (k == 21) check("t4_d2", seg, 8'h3F);
      if (k == 31) check("t4_d3_dash", seg, 8'h40);
    end

    // blink on digit 0 only
    dp_in = 4'h0; bcd_in = 16'h1234; blink_en = 4'b0001;
    do_reset();
    for (int k = 1; k <= 820; k++) begin
      tick();
      if (k == 161) check("t5_lit", {4'h0, an}, 8'h01);
      if (k == 201) check("t5_dark", {4'h0, an}, 8'h00);
      if (k == 211) check("t5_other_lit", {4'h0, an}, 8'h02);
      if (k == 401) check("t5_relit", seg, 8'h66);
    end

    // enable hold/resume and mid-frame reset
    blink_en = 4'h0;
    do_reset();
    repeat (25) tick();
    en = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      check("t6_off_an", {4'h0, an}, 8'h00);
    end
    en = 1'b1;
    tick();
    check("t6_resume_seg", seg, 8'h5B);
    check("t6_resume_an", {4'h0, an}, 8'h04);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    check("t6_rst_an", {4'h0, an}, 8'h00);
    rst = 1'b0;
    tick();
    check("t6_after_rst", seg, 8'h66);
    check("t6_after_rst_an", {4'h0, an}, 8'h01);

    // randomized traffic against the model
    for (int k = 0; k < 2500; k++) begin
      tick();
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 15) == 0)
          bcd_in[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 31) == 0) dp_in    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 127) == 0) blink_en = 4'($urandom_range(0, 15));
      en  = ($urandom_range(0, 19) != 0);
      rst = ($urandom_range(0, 399) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
